// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEFAULT_BITS = 8;
  localparam int DEFAULT_BUS  = 2;

  function automatic int depth_of(input int bus);
    return 1 << bus;
  endfunction

  // Clear-pointer type for the default geometry; the top derives its own from Bus.
  typedef logic [DEFAULT_BUS-1:0] clr_ptr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: write-first bypass, busy zeroing and output register.
// With REGFILE_ZERO_REG_EN defined, address 0 always reads as zero.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int Bits = DEFAULT_BITS,
  parameter int Bus  = DEFAULT_BUS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            zero,
  input  logic            wr_en,
  input  logic [Bus-1:0]  wa,
  input  logic [Bits-1:0] wd,
  input  logic [Bus-1:0]  ra,
  input  logic [Bits-1:0] mem_data,
  output logic [Bits-1:0] rd
);

  logic hit;
  assign hit = wr_en && (wa == ra);

  always_ff @(posedge clk) begin
    if (reset || zero) begin
      rd <= '0;
`ifdef REGFILE_ZERO_REG_EN
    end else if (ra == '0) begin
      rd <= '0;
`endif
    end else if (hit) begin
      rd <= wd;
    end else begin
      rd <= mem_data;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with a one-entry-per-cycle clear sweep.
// Optional macro REGFILE_ZERO_REG_EN makes entry 0 a hardwired zero.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int Bits = DEFAULT_BITS,
  parameter int Bus  = DEFAULT_BUS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WE,
  input  logic [Bus-1:0]  WA,
  input  logic [Bits-1:0] WD,
  input  logic [Bus-1:0]  RA1,
  input  logic [Bus-1:0]  RA2,
  input  logic            clear,
  output logic [Bits-1:0] RD1,
  output logic [Bits-1:0] RD2,
  output logic            busy
);

  localparam int DEPTH = depth_of(Bus);

  logic [Bits-1:0] mem [DEPTH];
  state_t          state;
  logic [Bus-1:0]  ptr;

  logic            wr_en;
  logic            sweep_en;
  logic            rd_zero;
  logic [Bits-1:0] mem_data1;
  logic [Bits-1:0] mem_data2;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_en = !reset && (state == IDLE) && WE && (WA != '0);
`else
  assign wr_en = !reset && (state == IDLE) && WE;
`endif

  assign sweep_en = !reset && (state == CLEAR);
  // Reads return zero on every edge where busy is or becomes high.
  assign rd_zero  = (state == CLEAR) || clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto inferred RAM.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[WA] <= WD;
    end
  end

  assign mem_data1 = mem[RA1];
  assign mem_data2 = mem[RA2];

  regfile_read_port #(.Bits(Bits), .Bus(Bus)) u_port1 (
    .clk      (clk),
    .reset    (reset),
    .zero     (rd_zero),
    .wr_en    (wr_en),
    .wa       (WA),
    .wd       (WD),
    .ra       (RA1),
    .mem_data (mem_data1),
    .rd       (RD1)
  );

  regfile_read_port #(.Bits(Bits), .Bus(Bus)) u_port2 (
    .clk      (clk),
    .reset    (reset),
    .zero     (rd_zero),
    .wr_en    (wr_en),
    .wa       (WA),
    .wd       (WD),
    .ra       (RA2),
    .mem_data (mem_data2),
    .rd       (RD2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (Bits=8, Bus=2).
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       reset;
  logic       WE;
  logic [1:0] WA;
  logic [7:0] WD;
  logic [1:0] RA1;
  logic [1:0] RA2;
  logic       clear;
  logic [7:0] RD1;
  logic [7:0] RD2;
  logic       busy;

  int pass_count = 0;
  int total_count = 0;

  regfile_2r1w #(.Bits(8), .Bus(2)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .RA1   (RA1),
    .RA2   (RA2),
    .clear (clear),
    .RD1   (RD1),
    .RD2   (RD2),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    WE = 1'b1; WA = a; WD = d;
    step();
    WE = 1'b0;
  endtask

  logic [7:0] e0;

  initial begin
    reset = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0; clear = 1'b0;
    step();
    reset = 1'b0;

    // 1: reset sweep
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i), {7'd0, busy}, 8'd1);
      check($sformatf("rst_rd1_%0d", i), RD1, 8'h00);
      check($sformatf("rst_rd2_%0d", i), RD2, 8'h00);
      step();
    end
    check("rst_busy_done", {7'd0, busy}, 8'd0);
    for (int a = 0; a < 4; a++) begin
      RA1 = 2'(a); RA2 = 2'(3 - a);
      step();
      check($sformatf("rst_read1_a%0d", a), RD1, 8'h00);
      check($sformatf("rst_read2_a%0d", 3 - a), RD2, 8'h00);
    end

    // 2: plain write/read and bypass
    RA1 = 2'd0; RA2 = 2'd0;
    write_reg(2'd2, 8'hA5);
    RA1 = 2'd2;
    step();
    check("wr_read_a2", RD1, 8'hA5);
    RA2 = 2'd3;
    write_reg(2'd3, 8'h3C);
    check("bypass_rd2_a3", RD2, 8'h3C);
    check("rd1_a2_stable", RD1, 8'hA5);

    // 5: both ports bypass the same address
    RA1 = 2'd1; RA2 = 2'd1;
    write_reg(2'd1, 8'h5A);
    check("dual_bypass_rd1", RD1, 8'h5A);
    check("dual_bypass_rd2", RD2, 8'h5A);

    // 6: entry 0 behaviour
`ifdef REGFILE_ZERO_REG_EN
    e0 = 8'h00;
`else
    e0 = 8'h77;
`endif
    RA1 = 2'd0;
    write_reg(2'd0, 8'h77);
    check("zero_bypass", RD1, e0);
    step();
    check("zero_read", RD1, e0);
    RA1 = 2'd1;
    write_reg(2'd1, 8'h77);
    check("a1_bypass_77", RD1, 8'h77);
    step();
    check("a1_read_77", RD1, 8'h77);

    // 3: fill then clear; writes during busy are dropped
    write_reg(2'd0, 8'd11);
    write_reg(2'd1, 8'd22);
    write_reg(2'd2, 8'd33);
    write_reg(2'd3, 8'd44);
`ifdef REGFILE_ZERO_REG_EN
    e0 = 8'd0;
`else
    e0 = 8'd11;
`endif
    RA1 = 2'd0; RA2 = 2'd3;
    step();
    check("fill_a0", RD1, e0);
    check("fill_a3", RD2, 8'd44);
    RA1 = 2'd1; RA2 = 2'd2;
    step();
    check("fill_a1", RD1, 8'd22);
    check("fill_a2", RD2, 8'd33);
    // write in the same cycle as clear: performed, but the read returns zero
    RA1 = 2'd2;
    clear = 1'b1; WE = 1'b1; WA = 2'd2; WD = 8'h99;
    step();
    clear = 1'b0;
    check("clr_start_rd1", RD1, 8'h00);
    WA = 2'd1; WD = 8'hFF; RA1 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_busy%0d", i), {7'd0, busy}, 8'd1);
      check($sformatf("clr_rd1_%0d", i), RD1, 8'h00);
      step();
    end
    WE = 1'b0;
    check("clr_busy_done", {7'd0, busy}, 8'd0);
    for (int a = 0; a < 4; a++) begin
      RA1 = 2'(a); RA2 = 2'(a);
      step();
      check($sformatf("clr_read1_a%0d", a), RD1, 8'h00);
      check($sformatf("clr_read2_a%0d", a), RD2, 8'h00);
    end

    // 4: reset mid-sweep restarts; clear during sweep is ignored
    write_reg(2'd3, 8'h42);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    check("mid_busy", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clear = (i == 1 || i == 2);
      check($sformatf("restart_busy%0d", i), {7'd0, busy}, 8'd1);
      step();
    end
    clear = 1'b0;
    check("restart_busy_done", {7'd0, busy}, 8'd0);
    RA2 = 2'd3;
    step();
    check("restart_a3_zero", RD2, 8'h00);
    write_reg(2'd3, 8'h81);
    step();
    check("post_sweep_write", RD2, 8'h81);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
